hazard_unit: RTL and testbench

- Producer-side counterpart to the pipeline's operand-forwarding logic. It handles the hazards that forwarding cannot resolve: load-use, multi-cycle mult/div HI/LO occupancy, and taken-branch flush.
- Sits in ID beside the register file. It drives PC write enable, IF/ID write/flush and the ID/EX bubble.
- It keeps a mult/div busy counter and a saturating stall-cycle performance counter.

---
 rtl/hazard_pkg.sv | 16 +
 rtl/hazard_unit.sv | 97 +++++++++
 tb/tb_hazard_unit.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the ID-stage hazard unit: stall reasons, FSM states, default latency.
package hazard_pkg;
  typedef enum logic [1:0] {
    NONE     = 2'd0,
    LOAD_USE = 2'd1,
    MULDIV   = 2'd2,
    FLUSH    = 2'd3
  } stall_reason_t;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } hz_state_t;

  localparam int MULDIV_LAT_DEF = 32;
endpackage

// File: rtl/hazard_unit.sv
// ID-stage hazard unit: load-use and HI/LO occupancy stalls, taken-branch flush,
// mult/div busy tracking and a saturating stall-cycle counter.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_W      = 5,
  parameter int MULDIV_LAT = MULDIV_LAT_DEF,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] IFID_src1,
  input  logic [REG_W-1:0] IFID_src2,
  input  logic             IFID_uses_src2,
  input  logic             IFID_muldiv,
  input  logic             IFID_reads_hilo,
  input  logic             IDEX_MemRead,
  input  logic [REG_W-1:0] IDEX_dest,
  input  logic             EX_branch_taken,
  input  logic             stat_clr,
  output logic             PC_write,
  output logic             IFID_write,
  output logic             IFID_flush,
  output logic             IDEX_bubble,
  output logic [1:0]       stall_reason,
  output logic             muldiv_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int MD_W = $clog2(MULDIV_LAT + 1);

  hz_state_t     state;
  logic [MD_W-1:0] md_cnt;
  stall_reason_t reason;
  logic          load_use, md_stall;

  assign muldiv_busy  = (state == MD_BUSY);
  assign stall_reason = reason;

  always_comb begin
    load_use    = IDEX_MemRead && (IDEX_dest != '0) &&
                  ((IDEX_dest == IFID_src1) || (IFID_uses_src2 && (IDEX_dest == IFID_src2)));
    md_stall    = muldiv_busy && (IFID_reads_hilo || IFID_muldiv);
    reason      = NONE;
    PC_write    = 1'b1;
    IFID_write  = 1'b1;
    IFID_flush  = 1'b0;
    IDEX_bubble = 1'b0;
    if (EX_branch_taken) begin
      reason      = FLUSH;
      IFID_flush  = 1'b1;
      IDEX_bubble = 1'b1;
    end else if (load_use || md_stall) begin
      reason      = load_use ? LOAD_USE : MULDIV;
      PC_write    = 1'b0;
      IFID_write  = 1'b0;
      IDEX_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      md_cnt       <= '0;
      stall_cycles <= '0;
    end else begin
      case (state)
        RUN: begin
          // Only an instruction that actually leaves ID starts the occupancy window;
          // a mult/div killed by a flush or held by a stall does not.
          if (IFID_muldiv && reason == NONE) begin
            state  <= MD_BUSY;
            md_cnt <= MD_W'(MULDIV_LAT);
          end
        end
        MD_BUSY: begin
          if (md_cnt == MD_W'(1)) begin
            state  <= RUN;
            md_cnt <= '0;
          end else begin
            md_cnt <= md_cnt - MD_W'(1);
          end
        end
        default: begin
          state  <= RUN;
          md_cnt <= '0;
        end
      endcase

      if (stat_clr)
        stall_cycles <= '0;
      else if ((reason == LOAD_USE || reason == MULDIV) && !(&stall_cycles))
        stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit with MULDIV_LAT=4 and a 4-bit stall counter.
module tb_hazard_unit;
  localparam int REG_W = 5;
  localparam int LAT   = 4;
  localparam int CW    = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [REG_W-1:0] IFID_src1, IFID_src2, IDEX_dest;
  logic             IFID_uses_src2, IFID_muldiv, IFID_reads_hilo;
  logic             IDEX_MemRead, EX_branch_taken, stat_clr;
  logic             PC_write, IFID_write, IFID_flush, IDEX_bubble, muldiv_busy;
  logic [1:0]       stall_reason;
  logic [CW-1:0]    stall_cycles;

  int checks = 0;
  int failures = 0;

  hazard_unit #(.REG_W(REG_W), .MULDIV_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .IFID_src1(IFID_src1), .IFID_src2(IFID_src2), .IFID_uses_src2(IFID_uses_src2),
    .IFID_muldiv(IFID_muldiv), .IFID_reads_hilo(IFID_reads_hilo),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_dest(IDEX_dest),
    .EX_branch_taken(EX_branch_taken), .stat_clr(stat_clr),
    .PC_write(PC_write), .IFID_write(IFID_write), .IFID_flush(IFID_flush),
    .IDEX_bubble(IDEX_bubble), .stall_reason(stall_reason),
    .muldiv_busy(muldiv_busy), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    IFID_src1 = '0; IFID_src2 = '0; IDEX_dest = '0;
    IFID_uses_src2 = 1'b0; IFID_muldiv = 1'b0; IFID_reads_hilo = 1'b0;
    IDEX_MemRead = 1'b0; EX_branch_taken = 1'b0; stat_clr = 1'b0;
  endtask

  initial begin
    int stalls;
    idle();
    rst_n = 1'b0;
    #3;
    chk("rst_pc_write", 32'(PC_write), 32'd1);
    chk("rst_ifid_write", 32'(IFID_write), 32'd1);
    chk("rst_flush", 32'(IFID_flush), 32'd0);
    chk("rst_bubble", 32'(IDEX_bubble), 32'd0);
    chk("rst_reason", 32'(stall_reason), 32'd0);
    chk("rst_busy", 32'(muldiv_busy), 32'd0);
    chk("rst_cnt", 32'(stall_cycles), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 1. load-use on rs
    IDEX_MemRead = 1'b1; IDEX_dest = 5'd5; IFID_src1 = 5'd5; IFID_src2 = 5'd3; IFID_uses_src2 = 1'b1;
    #1;
    chk("lu_reason", 32'(stall_reason), 32'd1);
    chk("lu_pc_write", 32'(PC_write), 32'd0);
    chk("lu_ifid_write", 32'(IFID_write), 32'd0);
    chk("lu_bubble", 32'(IDEX_bubble), 32'd1);
    chk("lu_flush", 32'(IFID_flush), 32'd0);
    tick();
    IDEX_MemRead = 1'b0;
    #1;
    chk("lu_after_reason", 32'(stall_reason), 32'd0);
    chk("lu_after_pc_write", 32'(PC_write), 32'd1);
    chk("lu_after_cnt", 32'(stall_cycles), 32'd1);

    // 2. $0 destination and unused rt never stall; used rt does
    idle();
    IDEX_MemRead = 1'b1; IDEX_dest = 5'd0; IFID_src1 = 5'd0;
    #1;
    chk("r0_reason", 32'(stall_reason), 32'd0);
    IDEX_dest = 5'd7; IFID_src1 = 5'd1; IFID_src2 = 5'd7; IFID_uses_src2 = 1'b0;
    #1;
    chk("rt_unused_reason", 32'(stall_reason), 32'd0);
    IFID_uses_src2 = 1'b1;
    #1;
    chk("rt_used_reason", 32'(stall_reason), 32'd1);
    IDEX_MemRead = 1'b0;
    tick();
    chk("lu_cnt_hold", 32'(stall_cycles), 32'd1);

    // 3. mult then mfhi: exactly LAT stall cycles; clear counter on the issue edge
    idle();
    IFID_muldiv = 1'b1; stat_clr = 1'b1;
    #1;
    chk("md_issue_reason", 32'(stall_reason), 32'd0);
    chk("md_issue_busy", 32'(muldiv_busy), 32'd0);
    tick();
    idle();
    IFID_reads_hilo = 1'b1;
    #1;
    chk("md_busy_after_issue", 32'(muldiv_busy), 32'd1);
    chk("md_cleared_cnt", 32'(stall_cycles), 32'd0);
    stalls = 0;
    for (int i = 0; i < 10; i++) begin
      if (stall_reason != 2'd2) break;
      stalls++;
      tick();
    end
    chk("md_stall_len", 32'(stalls), 32'(LAT));
    chk("md_busy_done", 32'(muldiv_busy), 32'd0);
    chk("md_pc_write_done", 32'(PC_write), 32'd1);
    chk("md_cnt", 32'(stall_cycles), 32'd4);

    // 4. branch beats load-use; mult/div in ID during flush is killed
    idle();
    IDEX_MemRead = 1'b1; IDEX_dest = 5'd5; IFID_src1 = 5'd5;
    EX_branch_taken = 1'b1; IFID_muldiv = 1'b1;
    #1;
    chk("fl_reason", 32'(stall_reason), 32'd3);
    chk("fl_flush", 32'(IFID_flush), 32'd1);
    chk("fl_bubble", 32'(IDEX_bubble), 32'd1);
    chk("fl_pc_write", 32'(PC_write), 32'd1);
    chk("fl_ifid_write", 32'(IFID_write), 32'd1);
    tick();
    chk("fl_cnt_unchanged", 32'(stall_cycles), 32'd4);
    chk("fl_md_killed", 32'(muldiv_busy), 32'd0);

    // 5. reset with md_cnt=2 abandons the mult/div
    idle();
    IFID_muldiv = 1'b1;
    tick();
    idle();
    IFID_reads_hilo = 1'b1;
    tick();
    tick();
    chk("rm_busy_before", 32'(muldiv_busy), 32'd1);
    chk("rm_cnt_before", 32'(stall_cycles), 32'd6);
    #1 rst_n = 1'b0;
    #1;
    chk("rm_busy_async", 32'(muldiv_busy), 32'd0);
    chk("rm_cnt_async", 32'(stall_cycles), 32'd0);
    chk("rm_reason_async", 32'(stall_reason), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rm_mfhi_reason", 32'(stall_reason), 32'd0);
    chk("rm_mfhi_pc_write", 32'(PC_write), 32'd1);
    tick();
    chk("rm_busy_after", 32'(muldiv_busy), 32'd0);
    chk("rm_cnt_after", 32'(stall_cycles), 32'd0);

    // 6. saturation and clear-beats-increment
    idle();
    IDEX_MemRead = 1'b1; IDEX_dest = 5'd9; IFID_src1 = 5'd9;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_cnt", 32'(stall_cycles), 32'd15);
    stat_clr = 1'b1;
    tick();
    chk("clr_cnt", 32'(stall_cycles), 32'd0);
    stat_clr = 1'b0;
    tick();
    chk("clr_resume_cnt", 32'(stall_cycles), 32'd1);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
